// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - data memory req/ready handshake between the MEM stage and memory
interface mem_access_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MIPS MEM stage: redirect resolve, stalling data memory access, MEM/WB register
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [3:0]  M_WB,
  input  logic        M_MemRead,
  input  logic        M_MemWrite,
  input  logic        M_Branch,
  input  logic        M_BNE,
  input  logic        M_jump,
  input  logic        M_jr,
  input  logic        M_ZeroFlag,
  input  logic [31:0] M_PCinc,
  input  logic [31:0] M_BranchAddResult,
  input  logic [31:0] M_ALUResult,
  input  logic [31:0] M_WriteMemData,
  input  logic [31:0] M_Read1,
  input  logic [25:0] M_offset,
  input  logic [4:0]  M_WriteRegData,
  mem_access_stage_if.master mem,
  output logic        M_Stall,
  output logic        PCSrc,
  output logic [31:0] PCTarget,
  output logic        MemErr,
  output logic [3:0]  WB_WB,
  output logic [31:0] WB_ReadData,
  output logic [31:0] WB_ALUResult,
  output logic [31:0] WB_PCinc,
  output logic [4:0]  WB_WriteReg
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

  logic [0:0] state;
  logic [7:0] cnt;

  logic access, misaligned, aligned, abort, rd_done, taken;

  assign access     = M_MemRead | M_MemWrite;
  assign misaligned = access & (M_ALUResult[1:0] != 2'b00);
  assign aligned    = access & ~misaligned;
  assign abort      = (state == WAIT) & aligned & ~mem.mem_ready & (cnt == TIMEOUT_CNT);
  assign rd_done    = aligned & ~M_MemWrite & mem.mem_ready;

  assign mem.mem_req   = Reset & aligned & ~abort;
  assign mem.mem_we    = M_MemWrite;
  assign mem.mem_addr  = M_ALUResult;
  assign mem.mem_wdata = M_WriteMemData;
  assign M_Stall       = Reset & aligned & ~mem.mem_ready & ~abort;

  // Redirect priority: jr, then jump, then a taken branch.
  assign taken = M_Branch & (M_BNE ? ~M_ZeroFlag : M_ZeroFlag);
  assign PCSrc = Reset & (M_jr | M_jump | taken);

  always_comb begin
    PCTarget = M_PCinc;
    if (M_jr)        PCTarget = M_Read1;
    else if (M_jump) PCTarget = {M_PCinc[31:28], M_offset, 2'b00};
    else if (taken)  PCTarget = M_BranchAddResult;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      MemErr       <= 1'b0;
      WB_WB        <= 4'd0;
      WB_ReadData  <= 32'd0;
      WB_ALUResult <= 32'd0;
      WB_PCinc     <= 32'd0;
      WB_WriteReg  <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (aligned && !mem.mem_ready) begin
            state <= WAIT;
            cnt   <= 8'd1;
          end
        end
        WAIT: begin
          if (!aligned || mem.mem_ready || abort) begin
            state <= IDLE;
            cnt   <= 8'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 8'd0;
        end
      endcase

      if (misaligned || abort) MemErr <= 1'b1;

      // Stalled, faulted or aborted instructions leave a bubble in MEM/WB.
      if (M_Stall || misaligned || abort) begin
        WB_WB        <= 4'd0;
        WB_ReadData  <= 32'd0;
        WB_ALUResult <= 32'd0;
        WB_PCinc     <= 32'd0;
        WB_WriteReg  <= 5'd0;
      end else begin
        WB_WB        <= M_WB;
        WB_ReadData  <= rd_done ? mem.mem_rdata : 32'd0;
        WB_ALUResult <= M_ALUResult;
        WB_PCinc     <= M_PCinc;
        WB_WriteReg  <= M_WriteRegData;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage
module tb_mem_access_stage;
  logic        Clk = 1'b0;
  logic        Reset;
  logic [3:0]  M_WB;
  logic        M_MemRead, M_MemWrite, M_Branch, M_BNE, M_jump, M_jr, M_ZeroFlag;
  logic [31:0] M_PCinc, M_BranchAddResult, M_ALUResult, M_WriteMemData, M_Read1;
  logic [25:0] M_offset;
  logic [4:0]  M_WriteRegData;
  logic        M_Stall, PCSrc, MemErr;
  logic [31:0] PCTarget, WB_ReadData, WB_ALUResult, WB_PCinc;
  logic [3:0]  WB_WB;
  logic [4:0]  WB_WriteReg;

  int tests = 0;
  int fails = 0;

  mem_access_stage_if bus ();

  mem_access_stage #(.TIMEOUT(4)) dut (
    .Clk(Clk), .Reset(Reset), .M_WB(M_WB),
    .M_MemRead(M_MemRead), .M_MemWrite(M_MemWrite), .M_Branch(M_Branch),
    .M_BNE(M_BNE), .M_jump(M_jump), .M_jr(M_jr), .M_ZeroFlag(M_ZeroFlag),
    .M_PCinc(M_PCinc), .M_BranchAddResult(M_BranchAddResult),
    .M_ALUResult(M_ALUResult), .M_WriteMemData(M_WriteMemData),
    .M_Read1(M_Read1), .M_offset(M_offset), .M_WriteRegData(M_WriteRegData),
    .mem(bus.master), .M_Stall(M_Stall), .PCSrc(PCSrc), .PCTarget(PCTarget),
    .MemErr(MemErr), .WB_WB(WB_WB), .WB_ReadData(WB_ReadData),
    .WB_ALUResult(WB_ALUResult), .WB_PCinc(WB_PCinc), .WB_WriteReg(WB_WriteReg)
  );

  always #5 Clk = ~Clk;

  task automatic idle_inputs();
    M_WB = 4'd0; M_MemRead = 1'b0; M_MemWrite = 1'b0; M_Branch = 1'b0;
    M_BNE = 1'b0; M_jump = 1'b0; M_jr = 1'b0; M_ZeroFlag = 1'b0;
    M_PCinc = 32'd0; M_BranchAddResult = 32'd0; M_ALUResult = 32'd0;
    M_WriteMemData = 32'd0; M_Read1 = 32'd0; M_offset = 26'd0; M_WriteRegData = 5'd0;
    bus.mem_ready = 1'b0; bus.mem_rdata = 32'd0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    idle_inputs();
    M_MemRead = 1'b1; M_ALUResult = 32'h100; M_WB = 4'b1001;
    @(negedge Clk); #1;
    tests++; if (M_Stall !== 1'b1) begin fails++; $display("FAIL reset_pre_stall: got %b expected 1", M_Stall); end
    Reset = 1'b0;
    #1;
    tests++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL reset_req_forced: got %b expected 0", bus.mem_req); end
    tests++; if (M_Stall !== 1'b0) begin fails++; $display("FAIL reset_stall_forced: got %b expected 0", M_Stall); end
    @(negedge Clk); @(negedge Clk); #1;
    tests++; if (WB_WB !== 4'd0 || WB_ReadData !== 32'd0 || WB_ALUResult !== 32'd0) begin fails++; $display("FAIL reset_wb: got %h/%h/%h expected 0", WB_WB, WB_ReadData, WB_ALUResult); end
    tests++; if (MemErr !== 1'b0) begin fails++; $display("FAIL reset_memerr: got %b expected 0", MemErr); end
    Reset = 1'b1;
    idle_inputs();
    #1;
    tests++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL reset_idle_req: got %b expected 0", bus.mem_req); end
    @(negedge Clk);
  endtask

  task automatic test_zero_wait_load();
    idle_inputs();
    M_MemRead = 1'b1; M_ALUResult = 32'h100; M_WB = 4'b1001; M_WriteRegData = 5'd7;
    M_PCinc = 32'h1004; bus.mem_ready = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
    #1;
    tests++; if (M_Stall !== 1'b0 || bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0) begin fails++; $display("FAIL zw_handshake: got stall=%b req=%b we=%b expected 0 1 0", M_Stall, bus.mem_req, bus.mem_we); end
    tests++; if (bus.mem_addr !== 32'h100) begin fails++; $display("FAIL zw_addr: got %h expected 00000100", bus.mem_addr); end
    @(negedge Clk); #1;
    tests++; if (WB_ReadData !== 32'hDEADBEEF) begin fails++; $display("FAIL zw_rdata: got %h expected deadbeef", WB_ReadData); end
    tests++; if (WB_WB !== 4'b1001 || WB_WriteReg !== 5'd7 || WB_PCinc !== 32'h1004) begin fails++; $display("FAIL zw_fields: got %b %0d %h expected 1001 7 00001004", WB_WB, WB_WriteReg, WB_PCinc); end
    idle_inputs();
    @(negedge Clk);
  endtask

  task automatic test_wait_store();
    idle_inputs();
    M_MemWrite = 1'b1; M_ALUResult = 32'h40; M_WriteMemData = 32'h12345678; M_WB = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (M_Stall !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_req !== 1'b1) begin fails++; $display("FAIL ws_stall%0d: got stall=%b we=%b req=%b expected 1 1 1", i, M_Stall, bus.mem_we, bus.mem_req); end
      tests++; if (bus.mem_wdata !== 32'h12345678) begin fails++; $display("FAIL ws_wdata%0d: got %h expected 12345678", i, bus.mem_wdata); end
      @(negedge Clk); #1;
      tests++; if (WB_WB !== 4'd0) begin fails++; $display("FAIL ws_bubble%0d: got %b expected 0000", i, WB_WB); end
    end
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hFFFFFFFF;
    #1;
    tests++; if (M_Stall !== 1'b0 || bus.mem_req !== 1'b1) begin fails++; $display("FAIL ws_done: got stall=%b req=%b expected 0 1", M_Stall, bus.mem_req); end
    @(negedge Clk); #1;
    tests++; if (WB_WB !== 4'b0010 || WB_ReadData !== 32'd0 || WB_ALUResult !== 32'h40) begin fails++; $display("FAIL ws_load: got %b %h %h expected 0010 00000000 00000040", WB_WB, WB_ReadData, WB_ALUResult); end
    idle_inputs();
    @(negedge Clk);
  endtask

  task automatic test_timeout();
    idle_inputs();
    M_MemRead = 1'b1; M_ALUResult = 32'h80; M_WB = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++; if (M_Stall !== 1'b1) begin fails++; $display("FAIL to_stall%0d: got %b expected 1", i, M_Stall); end
      @(negedge Clk); #1;
      tests++; if (WB_WB !== 4'd0 || MemErr !== 1'b0) begin fails++; $display("FAIL to_wait%0d: got wb=%b err=%b expected 0000 0", i, WB_WB, MemErr); end
    end
    #1;
    tests++; if (bus.mem_req !== 1'b0 || M_Stall !== 1'b0) begin fails++; $display("FAIL to_abort: got req=%b stall=%b expected 0 0", bus.mem_req, M_Stall); end
    @(negedge Clk); #1;
    tests++; if (MemErr !== 1'b1 || WB_WB !== 4'd0 || WB_ALUResult !== 32'd0) begin fails++; $display("FAIL to_err: got err=%b wb=%b alu=%h expected 1 0000 0", MemErr, WB_WB, WB_ALUResult); end
    idle_inputs();
    M_WB = 4'b0100; M_ALUResult = 32'h55;
    @(negedge Clk); #1;
    tests++; if (MemErr !== 1'b1) begin fails++; $display("FAIL to_sticky: got %b expected 1", MemErr); end
    tests++; if (WB_WB !== 4'b0100 || WB_ALUResult !== 32'h55) begin fails++; $display("FAIL to_recover: got %b %h expected 0100 00000055", WB_WB, WB_ALUResult); end
    Reset = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    idle_inputs();
    #1;
    tests++; if (MemErr !== 1'b0) begin fails++; $display("FAIL to_clear: got %b expected 0", MemErr); end
  endtask

  task automatic test_misaligned();
    idle_inputs();
    M_MemRead = 1'b1; M_ALUResult = 32'h102; M_WB = 4'b1001; M_WriteRegData = 5'd3;
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
    #1;
    tests++; if (bus.mem_req !== 1'b0 || M_Stall !== 1'b0) begin fails++; $display("FAIL mis_req: got req=%b stall=%b expected 0 0", bus.mem_req, M_Stall); end
    @(negedge Clk); #1;
    tests++; if (MemErr !== 1'b1) begin fails++; $display("FAIL mis_err: got %b expected 1", MemErr); end
    tests++; if (WB_WB !== 4'd0 || WB_ReadData !== 32'd0 || WB_WriteReg !== 5'd0) begin fails++; $display("FAIL mis_bubble: got %b %h %0d expected 0", WB_WB, WB_ReadData, WB_WriteReg); end
    idle_inputs();
    Reset = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  task automatic test_redirect();
    idle_inputs();
    M_Branch = 1'b1; M_BNE = 1'b1; M_ZeroFlag = 1'b0; M_BranchAddResult = 32'h200; M_PCinc = 32'h104;
    #1;
    tests++; if (PCSrc !== 1'b1 || PCTarget !== 32'h200) begin fails++; $display("FAIL rd_bne: got %b %h expected 1 00000200", PCSrc, PCTarget); end
    M_ZeroFlag = 1'b1;
    #1;
    tests++; if (PCSrc !== 1'b0 || PCTarget !== 32'h104) begin fails++; $display("FAIL rd_bne_nt: got %b %h expected 0 00000104", PCSrc, PCTarget); end
    M_BNE = 1'b0;
    #1;
    tests++; if (PCSrc !== 1'b1 || PCTarget !== 32'h200) begin fails++; $display("FAIL rd_beq: got %b %h expected 1 00000200", PCSrc, PCTarget); end
    idle_inputs();
    M_jump = 1'b1; M_PCinc = 32'h40000010; M_offset = 26'h0000010;
    #1;
    tests++; if (PCSrc !== 1'b1 || PCTarget !== 32'h40000040) begin fails++; $display("FAIL rd_jump: got %b %h expected 1 40000040", PCSrc, PCTarget); end
    M_jr = 1'b1; M_Read1 = 32'h80;
    #1;
    tests++; if (PCSrc !== 1'b1 || PCTarget !== 32'h80) begin fails++; $display("FAIL rd_jr: got %b %h expected 1 00000080", PCSrc, PCTarget); end
    Reset = 1'b0;
    #1;
    tests++; if (PCSrc !== 1'b0) begin fails++; $display("FAIL rd_reset: got %b expected 0", PCSrc); end
    Reset = 1'b1;
    idle_inputs();
    @(negedge Clk);
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    M_MemRead = 1'b1; M_ALUResult = 32'h10; M_WB = 4'b1001; bus.mem_ready = 1'b0;
    #1;
    tests++; if (M_Stall !== 1'b1) begin fails++; $display("FAIL b2b_wait: got %b expected 1", M_Stall); end
    @(negedge Clk);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hA5A5A5A5;
    @(negedge Clk); #1;
    tests++; if (WB_ReadData !== 32'hA5A5A5A5) begin fails++; $display("FAIL b2b_first: got %h expected a5a5a5a5", WB_ReadData); end
    M_ALUResult = 32'h14; bus.mem_rdata = 32'h5A5A5A5A;
    #1;
    tests++; if (bus.mem_req !== 1'b1 || M_Stall !== 1'b0) begin fails++; $display("FAIL b2b_req: got req=%b stall=%b expected 1 0", bus.mem_req, M_Stall); end
    @(negedge Clk); #1;
    tests++; if (WB_ReadData !== 32'h5A5A5A5A || WB_ALUResult !== 32'h14) begin fails++; $display("FAIL b2b_second: got %h %h expected 5a5a5a5a 00000014", WB_ReadData, WB_ALUResult); end
    idle_inputs();
    @(negedge Clk);
  endtask

  initial begin
    idle_inputs();
    Reset = 1'b0;
    @(negedge Clk); @(negedge Clk);
    test_reset();
    test_zero_wait_load();
    test_wait_store();
    test_timeout();
    test_misaligned();
    test_redirect();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the five-stage MIPS pipeline: sits between the EX/MEM pipeline register and the WB stage. It resolves branch, jump and jr redirects from the EX/MEM outputs and runs a req/ready handshake to an external data memory, stalling the pipeline while the memory is busy. It also contains the MEM/WB pipeline register that feeds write-back.

## Interface
Parameters:
- TIMEOUT, 16: maximum WAIT cycles before an access is aborted (valid range 1–255).

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-low reset; sampled on the rising edge of Clk.
- M_WB  in  4  write-back control from EX/MEM; all-zero means no-op.
- M_MemRead, M_MemWrite, M_Branch, M_BNE, M_jump, M_jr  in  1 each  control from EX/MEM.
- M_ZeroFlag  in  1  ALU zero.
- M_PCinc, M_BranchAddResult, M_ALUResult, M_WriteMemData, M_Read1  in  32 each  datapath from EX/MEM.
- M_offset  in  26  jump field.
- M_WriteRegData  in  5  destination register number.
- mem_ready  in  1  memory completes the current request.
- mem_rdata  in  32  read data; valid when mem_ready=1.
- mem_req  out  1  access request.
- mem_we  out  1  1 = write.
- mem_addr, mem_wdata  out  32 each  address and store data.
- M_Stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM.
- PCSrc  out  1  redirect fetch.
- PCTarget  out  32  redirect address.
- MemErr  out  1  sticky error flag.
- WB_WB  out  4  MEM/WB write-back control.
- WB_ReadData, WB_ALUResult, WB_PCinc  out  32 each  MEM/WB datapath.
- WB_WriteReg  out  5  MEM/WB destination register.

## Operation
- access = M_MemRead | M_MemWrite; mem_we = M_MemWrite, which wins if both are set.
- mem_addr = M_ALUResult; mem_wdata = M_WriteMemData.
- Misaligned access (access with M_ALUResult[1:0]≠0):
  - mem_req stays 0 and M_Stall stays 0.
  - MemErr is set.
  - MEM/WB loads a bubble (all WB_* = 0).
- FSM states: IDLE, WAIT.
  - IDLE, aligned access: mem_req=1 and M_Stall = ~mem_ready.
    - mem_ready=1: the access completes this edge and the state stays IDLE.
    - mem_ready=0: go to WAIT and set cnt=1.
  - WAIT: mem_req=1 and M_Stall = ~mem_ready.
    - mem_ready=1: complete and return to IDLE.
    - cnt==TIMEOUT with mem_ready=0: abort.
    - otherwise cnt increments.
  - Abort: mem_req=0 and M_Stall=0 that cycle, MemErr is set, MEM/WB loads a bubble, and the state returns to IDLE.
  - Address, data and control inputs are held stable by the stall, so they are not re-registered.
- MEM/WB load:
  - Loads every edge where M_Stall=0.
  - Loads a bubble (all zero) on edges where M_Stall=1.
  - On a read completion, WB_ReadData = mem_rdata; otherwise WB_ReadData = 0.
  - The other WB_* fields copy their M_* counterparts.
- Redirect (combinational), priority jr > jump > branch:
  - jr: PCTarget = M_Read1.
  - jump: PCTarget = {M_PCinc[31:28], M_offset, 2'b00}.
  - branch taken = M_Branch & (M_BNE ? ~M_ZeroFlag : M_ZeroFlag): PCTarget = M_BranchAddResult.
  - PCSrc = M_jr | M_jump | taken.
  - Otherwise PCTarget = M_PCinc.
- MemErr is sticky until reset.
- While Reset=0, mem_req, M_Stall and PCSrc are forced to 0.

## Timing
- Reset edge: state=IDLE, cnt=0, MemErr=0, all WB_* = 0.
- A reset edge mid-WAIT abandons the access, with no bubble beyond the reset values.
- Zero-wait access (mem_ready high in the request cycle): no stall; MEM/WB updates at that edge.
- Access with N wait cycles (mem_ready first high N cycles after request): M_Stall high for exactly N cycles; MEM/WB holds a bubble for N edges, then loads data.
- Timeout: M_Stall high for TIMEOUT cycles; the abort edge follows.
- Back-to-back accesses: the next instruction's request starts in IDLE the cycle after completion, with no idle gap.
- Redirect outputs are valid in the same cycle the instruction occupies EX/MEM and carry no latency.

## Test plan
- Reset: hold Reset=0 for 2 edges during an active WAIT → state IDLE, mem_req=0, all WB_*=0, MemErr=0.
- Zero-wait load: M_MemRead=1, addr 0x100, mem_ready=1, rdata 0xDEADBEEF, WB=4'b1001 → M_Stall=0, and next edge WB_ReadData=0xDEADBEEF, WB_WB=4'b1001.
- 3-wait store: M_MemWrite=1, addr 0x40, wdata 0x12345678, mem_ready high on the 4th cycle → M_Stall=1 for 3 cycles, mem_we=1 throughout, WB_WB=0 for 3 edges, WB_ReadData=0 after completion.
- Timeout with TIMEOUT=4: load, mem_ready stuck low → M_Stall=1 for 4 cycles, then mem_req=0, MemErr=1 (sticky), MEM/WB bubble.
- Misaligned load: addr 0x102 → mem_req=0, M_Stall=0, MemErr=1, bubble.
- Redirects, one cycle each:
  - BNE with Zero=0, BranchAddResult=0x200 → PCSrc=1, PCTarget=0x200.
  - jump with PCinc=0x40000010, offset=0x0000010 → PCTarget=0x40000040.
  - jr and jump both set with Read1=0x80 → PCTarget=0x80.
